lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Load/store initiator for the MEM stage: issues word-wide accesses to the word-addressed
//  data memory (async read, write on posedge when write-enable is high). Handles lb/lh/lw/lbu/lhu
//  and sb/sh/sw; sub-word stores are done as read-modify-write. Flags misaligned, illegal-funct3
//  and out-of-range requests. Sits between pipeline MEM stage (valid/ready) and data memory.
// PARAMETERS
//  MEM_WORDS  1024  memory depth in 32-bit words; byte addr >= MEM_WORDS*4 is out of range
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit can accept (high only in IDLE)
//  req_we       in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores: 000/001/010)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (low byte/half used for sb/sh)
//  resp_valid   out  1   one-cycle completion pulse; no backpressure
//  resp_rdata   out  32  load result, sign/zero-extended; 0 for stores and errors
//  resp_err     out  1   qualified by resp_valid: misaligned/illegal/out-of-range
//  mem_addr     out  32  {addr[31:2],2'b00} of latched request; 0 in IDLE
//  mem_wr_en    out  1   memory write enable
//  mem_wr_data  out  32  full word to write
//  mem_rd_data  in   32  word read from mem_addr (combinational)
// BEHAVIOUR
//  Reset: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_addr=0,
//   mem_wr_data=0, request latches cleared. Reset mid-operation aborts; mem_wr_en drops
//   asynchronously, so a write is performed only if its posedge occurred before reset.
//  Accept on posedge with req_valid & req_ready; latch we/funct3/addr/wdata.
//  States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP. mem_wr_en=1 only in WRITE and RMW_WR.
//  IDLE: accept -> error? RESP : load? LOAD : sw? WRITE : RMW_RD.
//  LOAD: capture mem_rd_data; select byte addr[1:0] / half addr[1]; extend per funct3 -> RESP.
//  WRITE: mem_wr_data=wdata -> RESP.
//  RMW_RD: capture old word -> RMW_WR. RMW_WR: write old word with target byte/half replaced -> RESP.
//  RESP: resp_valid=1 one cycle, req_ready=0 -> IDLE. resp_* registered, cleared next cycle.
//  Latency (accept edge to resp_valid cycle): error 1, load 2, sw 2, sb/sh 3 cycles.
//  Back-to-back: next accept no earlier than the cycle after RESP (IDLE).
//  Error: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0; funct3 not listed (incl. load 011/110/111,
//   store 1xx); addr >= MEM_WORDS*4. Error -> no memory access, resp_rdata=0, resp_err=1.
//  Little-endian: byte k = word[8k+7:8k]; half at addr[1]=1 = word[31:16].
//  req_* changes while busy are ignored (only latched copies drive memory).
// TESTING
//  sw 0x000 data 0xDEADBEEF, then lw 0x000 -> mem_wr_en one cycle; load resp_rdata=0xDEADBEEF, err=0
//  word 0x11223344 at 0x8; lb 0xB -> 0x00000011; lh 0xA -> 0x00001122; lbu 0x9 -> 0x00000033
//  word 0x80FF7F01 at 0xC; lb 0xE -> 0xFFFFFFFF; lhu 0xE -> 0x000080FF; lh 0xE -> 0xFFFF80FF
//  word 0x11223344 at 0x8; sb 0x9 data 0xAA -> word 0x1122AA44; sh 0xA data 0xBEEF -> 0xBEEFAA44, latency 3
//  lw 0x2, sh 0x5, lw MEM_WORDS*4, funct3 011 -> resp_err=1 after 1 cycle, mem_wr_en never high
//  rst_n low during RMW_RD -> all outputs 0 immediately, memory word unchanged, req_ready=1 after release

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM pipeline stage and a word-addressed data memory.
// Sub-word stores are performed as read-modify-write; bad requests complete with resp_err.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  // First byte address past the end of memory (33 bits so 4 GiB never wraps).
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic req_legal_c;
  logic req_misal_c;
  logic req_oor_c;
  logic req_err_c;

  // Extract and extend the addressed byte/half/word from a memory word.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Replace the addressed byte or half of the old word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic is_half,
                                              input logic [1:0] off, input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] ins;
    if (is_half) begin
      mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      ins  = {d, d};
    end else begin
      mask = 32'h0000_00FF << {off, 3'b000};
      ins  = {4{d[7:0]}};
    end
    return (old & ~mask) | (ins & mask);
  endfunction

  // Classify the incoming request: illegal funct3, misalignment, out of range.
  always_comb begin
    req_legal_c = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_legal_c = 1'b1;
        default:                req_legal_c = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal_c = 1'b1;
        default:                                req_legal_c = 1'b0;
      endcase
    end
    req_misal_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_oor_c   = ({1'b0, req_addr} >= ADDR_LIMIT);
    req_err_c   = !req_legal_c || req_misal_c || req_oor_c;
  end

  // Sequencer with registered memory and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 32'h0;
      lat_funct3  <= 3'b000;
      lat_off     <= 2'b00;
      lat_wdata   <= 16'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err_c) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (!req_we) begin
                state <= S_LOAD;
              end else if (req_funct3[1]) begin
                state       <= S_WRITE;
                mem_wr_en   <= 1'b1;
                mem_wr_data <= req_wdata;
              end else begin
                state <= S_RMW_RD;
              end
            end
          end
        end
        S_LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext(mem_rd_data, lat_funct3, lat_off);
          state      <= S_RESP;
        end
        S_WRITE: begin
          mem_wr_en  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RMW_RD: begin
          mem_wr_data <= store_merge(mem_rd_data, lat_funct3[0], lat_off, lat_wdata);
          mem_wr_en   <= 1'b1;
          state       <= S_RMW_WR;
        end
        S_RMW_WR: begin
          mem_wr_en  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          state       <= S_IDLE;
          req_ready   <= 1'b1;
          mem_addr    <= 32'h0;
          mem_wr_data <= 32'h0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural word memory.
module tb_lsu_mem_master;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_bad;
  int          cyc;
  int          wr_cycles;
  logic [31:0] mem [0:MEM_WORDS-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge.
  assign mem_rd_data = (mem_addr < 32'(MEM_WORDS * 4)) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      wr_cycles <= wr_cycles + 1;
      if (mem_addr < 32'(MEM_WORDS * 4)) mem[mem_addr[11:2]] <= mem_wr_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Present one request when ready, queue its expected response, then scramble req_*.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input string nm);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w = w + 1;
    end
    if (!req_ready) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: req_ready timeout got 0 want 1", nm);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    e.rdata = er;
    e.err   = ee;
    e.lat   = lat;
    e.acc   = cyc;
    e.name  = nm;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFC;
    req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w = w + 1;
    end
    if (sb_q.size() != 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL resp_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every resp_valid cycle pops one expectation and compares data, err, latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        n_vec = n_vec + 1;
        if (sb_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_resp: got rdata=%h err=%b want no response", resp_rdata, resp_err);
        end else begin
          e = sb_q.pop_front();
          if (resp_rdata !== e.rdata || resp_err !== e.err || (cyc - e.acc) != e.lat) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                     e.name, resp_rdata, resp_err, cyc - e.acc, e.rdata, e.err, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    n_vec = 0;
    n_bad = 0;
    cyc = 0;
    wr_cycles = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load back.
    w0 = wr_cycles;
    issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw_0");
    wait_idle();
    chk("sw_wr_pulses", 32'(wr_cycles - w0), 32'h1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw_0");
    wait_idle();

    // Preload test words, then sub-word loads.
    issue(1'b1, 3'b010, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 2, "sw_8");
    issue(1'b1, 3'b010, 32'hC, 32'h80FF_7F01, 32'h0, 1'b0, 2, "sw_c");
    issue(1'b0, 3'b000, 32'hB, 32'h0, 32'h0000_0011, 1'b0, 2, "lb_b");
    issue(1'b0, 3'b001, 32'hA, 32'h0, 32'h0000_1122, 1'b0, 2, "lh_a");
    issue(1'b0, 3'b100, 32'h9, 32'h0, 32'h0000_0033, 1'b0, 2, "lbu_9");
    issue(1'b0, 3'b000, 32'h8, 32'h0, 32'h0000_0044, 1'b0, 2, "lb_8");
    issue(1'b0, 3'b000, 32'hE, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, "lb_e");
    issue(1'b0, 3'b101, 32'hE, 32'h0, 32'h0000_80FF, 1'b0, 2, "lhu_e");
    issue(1'b0, 3'b001, 32'hE, 32'h0, 32'hFFFF_80FF, 1'b0, 2, "lh_e");
    issue(1'b0, 3'b101, 32'hC, 32'h0, 32'h0000_7F01, 1'b0, 2, "lhu_c");
    issue(1'b0, 3'b100, 32'hF, 32'h0, 32'h0000_0080, 1'b0, 2, "lbu_f");
    wait_idle();

    // Read-modify-write stores (upper wdata bits must be ignored).
    w0 = wr_cycles;
    issue(1'b1, 3'b000, 32'h9, 32'h1234_56AA, 32'h0, 1'b0, 3, "sb_9");
    wait_idle();
    chk("sb_wr_pulses", 32'(wr_cycles - w0), 32'h1);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'h1122_AA44, 1'b0, 2, "lw_after_sb");
    issue(1'b1, 3'b001, 32'hA, 32'h7777_BEEF, 32'h0, 1'b0, 3, "sh_a");
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, 2, "lw_after_sh");
    wait_idle();

    // Error cases: one-cycle error response, no memory write.
    w0 = wr_cycles;
    issue(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1, "err_lw_2");
    issue(1'b1, 3'b001, 32'h5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_sh_5");
    issue(1'b0, 3'b010, 32'(MEM_WORDS * 4), 32'h0, 32'h0, 1'b1, 1, "err_lw_oor");
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, "err_f3_011");
    issue(1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b1, 1, "err_st_f3_100");
    issue(1'b1, 3'b010, 32'hA, 32'h0, 32'h0, 1'b1, 1, "err_sw_a");
    issue(1'b1, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, 1, "err_sb_oor");
    wait_idle();
    chk("err_wr_pulses", 32'(wr_cycles - w0), 32'h0);
    chk("mem_word8_after_err", mem[2], 32'hBEEF_AA44);

    // Reset while in RMW_RD aborts the store.
    issue(1'b1, 3'b000, 32'h8, 32'h0000_0055, 32'h0, 1'b0, 3, "sb_aborted");
    sb_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("abort_mem_wr_data", mem_wr_data, 32'h0);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    chk("abort_resp_err", 32'(resp_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_unchanged", mem[2], 32'hBEEF_AA44);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, 2, "lw_after_abort");
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
